ofdm_cp_remover: RTL
====================

OFDM_CP_REMOVER -- requirements
Module: ofdm_cp_remover

Interface
REQ-001 SHALL have parameter ITEM_W, default 32: sample width (sc16, I in [31:16], Q in [15:0]).
REQ-002 SHALL have parameter MAX_FFT_LOG2, default 10: log2 of the largest supported FFT size (1024).
REQ-003 SHALL have parameter SYM_CNT_W, default 8: width of the symbols-per-frame configuration.
REQ-004 SHALL have port ce_clk, input, 1: single clock for all logic.
REQ-005 SHALL have port ce_rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port cfg_fft_size, input, MAX_FFT_LOG2+1: useful samples per symbol, legal range 1..2^MAX_FFT_LOG2.
REQ-007 SHALL have port cfg_cp_len, input, MAX_FFT_LOG2: cyclic-prefix samples per symbol, 0 allowed.
REQ-008 SHALL have port cfg_num_sym, input, SYM_CNT_W: OFDM symbols per frame, value 0 treated as 1.
REQ-009 SHALL have ports s_axis_tdata, s_axis_tvalid, s_axis_tready, s_axis_tuser (ITEM_W,1,1,1): sample input from the Schmidl-Cox stage; tuser=1 marks the first CP sample of a frame (sync trigger).
REQ-010 SHALL have port s_axis_tlast, input, 1: upstream packet boundary, ignored for framing.
REQ-011 SHALL have ports m_axis_tdata, m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser (ITEM_W,1,1,1,1): CP-stripped output; tlast on the last sample of each symbol, tuser on the first sample of each frame.
REQ-012 SHALL have port busy, output, 1: high while a frame is in progress (state not IDLE).
REQ-013 SHALL have port frame_count, output, 32: number of frames fully emitted since reset, wraps at 2^32.

Function
REQ-014 SHALL implement states IDLE, CP and SYM.
REQ-015 In IDLE, s_axis_tready SHALL be 1, and every accepted beat with tuser=0 SHALL be discarded.
REQ-016 An accepted beat with tuser=1 in IDLE SHALL latch cfg_fft_size, cfg_cp_len and cfg_num_sym, clear the sample and symbol counters, and count as sample 0 of the first CP; go to CP, or go to SYM with that beat as useful sample 0 when cp_len=0.
REQ-017 Config changes during a frame SHALL have no effect until the next trigger.
REQ-018 In CP, s_axis_tready SHALL be 1; exactly cp_len beats per symbol SHALL be discarded, then the state SHALL go to SYM.
REQ-019 In SYM, exactly fft_size accepted beats SHALL be forwarded unchanged in tdata.
REQ-020 The last forwarded sample of a symbol SHALL carry m_axis_tlast=1.
REQ-021 The first forwarded sample of a frame SHALL carry m_axis_tuser=1.
REQ-022 After the last symbol sample: if symbols emitted < num_sym, go to CP (or stay in SYM when cp_len=0) for the next symbol; otherwise go to IDLE and increment frame_count.
REQ-023 s_axis_tuser on beats accepted in CP or SYM SHALL be ignored (no retrigger).
REQ-024 The output SHALL be a one-deep register stage; latency from input acceptance to m_axis_tvalid SHALL be 1 cycle.
REQ-025 In SYM, s_axis_tready SHALL equal (!m_axis_tvalid || m_axis_tready).
REQ-026 m_axis_tvalid SHALL stay high and tdata/tlast/tuser SHALL stay stable until m_axis_tready=1.
REQ-027 A beat is transferred only when tvalid&&tready are both 1; counters SHALL advance only on transfers.
REQ-028 The registered output SHALL drain normally after the state returns to IDLE.
REQ-029 Discarded beats in IDLE or CP SHALL not disturb a pending output beat.
REQ-030 Counters SHALL be MAX_FFT_LOG2+1 bits wide (samples) and SYM_CNT_W+1 bits wide (symbols); no overflow occurs for legal config.

Reset
REQ-031 On ce_rst=1 at a rising ce_clk edge, the state SHALL go to IDLE and all counters SHALL clear, including frame_count=0.
REQ-032 During and after reset: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdata=0, busy=0.
REQ-033 s_axis_tready SHALL be 0 while ce_rst=1.
REQ-034 Reset asserted mid-frame SHALL abort the frame, discard any pending output beat, and leave frame_count=0.

Verification
REQ-035 fft=16, cp=8, nsym=1, trigger on sample 100 of a ramp (sample n = n), m_tready=1: output is exactly 108..123, tlast on 123, tuser on 108, frame_count=1, busy low after.
REQ-036 fft=16, cp=8, nsym=4, random 25% stalls on both sides: 64 outputs, i.e. 4 blocks of 16 each preceded by a skipped 8, with tlast every 16th sample, data order preserved, no duplicates.
REQ-037 cp=0, fft=4, nsym=2, trigger beat value 7: output is 7..14, tlast on 10 and 14.
REQ-038 A second tuser pulse inside the frame of REQ-035: output is identical to REQ-035; a trigger after return to IDLE starts frame 2, so frame_count=2.
REQ-039 Hold m_tready=0 for 20 cycles mid-symbol: m_tvalid stays high, tdata stays stable, s_tready=0, and no samples are lost.
REQ-040 Assert ce_rst at output sample 5 of 16: m_tvalid=0 the next cycle, frame_count=0, busy=0; a new trigger then yields a clean frame.

Source files
------------

// File: rtl/ofdm_cp_remover.sv
// Cyclic-prefix remover: strips cp_len samples ahead of each fft_size-sample symbol in a triggered frame.
// Latency 1 cycle through a one-deep output register; input is held off in SYM only when that register cannot drain.
module ofdm_cp_remover #(
  parameter int ITEM_W       = 32,
  parameter int MAX_FFT_LOG2 = 10,
  parameter int SYM_CNT_W    = 8
) (
  input  logic                    ce_clk,
  input  logic                    ce_rst,
  input  logic [MAX_FFT_LOG2:0]   cfg_fft_size,
  input  logic [MAX_FFT_LOG2-1:0] cfg_cp_len,
  input  logic [SYM_CNT_W-1:0]    cfg_num_sym,
  input  logic [ITEM_W-1:0]       s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tuser,
  input  logic                    s_axis_tlast,
  output logic [ITEM_W-1:0]       m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tuser,
  output logic                    busy,
  output logic [31:0]             frame_count
);

  localparam int SW = MAX_FFT_LOG2 + 1;
  localparam int NW = SYM_CNT_W + 1;

  typedef enum logic [1:0] {IDLE, CP, SYM} state_t;
  state_t state, state_nxt;

  logic [SW-1:0]           fft_q, smp_cnt;
  logic [MAX_FFT_LOG2-1:0] cp_q;
  logic [NW-1:0]           nsym_q, sym_cnt;

  logic [SW-1:0]           cur_fft, cur_smp, smp_inc;
  logic [MAX_FFT_LOG2-1:0] cur_cp;
  logic [NW-1:0]           cur_nsym, cur_sym, sym_inc, cfg_nsym_eff;
  logic trig, in_sym, out_free, acc, step, cp_end, fft_end, frame_end;
  logic unused_tlast;

  assign unused_tlast = s_axis_tlast;

  // A trigger beat is processed with the live config and zeroed counters as if already latched.
  assign trig         = (state == IDLE) && s_axis_tuser;
  assign cfg_nsym_eff = (cfg_num_sym == '0) ? NW'(1) : {1'b0, cfg_num_sym};
  assign cur_fft      = trig ? cfg_fft_size : fft_q;
  assign cur_cp       = trig ? cfg_cp_len   : cp_q;
  assign cur_nsym     = trig ? cfg_nsym_eff : nsym_q;
  assign cur_smp      = trig ? '0 : smp_cnt;
  assign cur_sym      = trig ? '0 : sym_cnt;
  assign in_sym       = trig ? (cfg_cp_len == '0) : (state == SYM);

  assign smp_inc   = cur_smp + 1'b1;
  assign sym_inc   = cur_sym + 1'b1;
  assign cp_end    = (smp_inc == {1'b0, cur_cp});
  assign fft_end   = (smp_inc == cur_fft);
  assign frame_end = (sym_inc == cur_nsym);

  assign out_free = !m_axis_tvalid || m_axis_tready;
  assign acc      = s_axis_tvalid && s_axis_tready;
  assign step     = acc && ((state != IDLE) || s_axis_tuser);

  always_ff @(posedge ce_clk) begin
    if (ce_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (step) begin
      if (!in_sym)      state_nxt = cp_end ? SYM : CP;
      else if (fft_end) state_nxt = frame_end ? IDLE : ((cur_cp == '0) ? SYM : CP);
      else              state_nxt = SYM;
    end
  end

  // A cp_len=0 trigger is forwarded at once, so it waits for the output register like any SYM beat.
  always_comb begin
    s_axis_tready = 1'b0;
    busy          = (state != IDLE);
    if (!ce_rst) begin
      case (state)
        IDLE:    s_axis_tready = !(s_axis_tuser && (cfg_cp_len == '0)) || out_free;
        CP:      s_axis_tready = 1'b1;
        SYM:     s_axis_tready = out_free;
        default: s_axis_tready = 1'b0;
      endcase
    end
  end

  always_ff @(posedge ce_clk) begin
    if (ce_rst) begin
      fft_q         <= '0;
      cp_q          <= '0;
      nsym_q        <= '0;
      smp_cnt       <= '0;
      sym_cnt       <= '0;
      frame_count   <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
    end else begin
      if (trig && acc) begin
        fft_q  <= cfg_fft_size;
        cp_q   <= cfg_cp_len;
        nsym_q <= cfg_nsym_eff;
      end
      if (step) begin
        smp_cnt <= (in_sym ? fft_end : cp_end) ? '0 : smp_inc;
        if (in_sym && fft_end) begin
          sym_cnt <= frame_end ? '0 : sym_inc;
          if (frame_end) frame_count <= frame_count + 32'd1;
        end else begin
          sym_cnt <= cur_sym;
        end
      end
      if (step && in_sym) begin
        m_axis_tdata  <= s_axis_tdata;
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= fft_end;
        m_axis_tuser  <= (cur_sym == '0) && (cur_smp == '0);
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule
